vlan_stripper: RTL and testbench
================================

# vlan_stripper

RX-path counterpart of the VIU TX VLAN insertion stage. Sits between the CMAC RX stream and the RX gateway. It detects an 802.1Q tag at byte offset 12, removes the 4 tag bytes, and compacts the frame by shifting it 4 bytes toward byte 0. It presents the decoded routing identity to the gateway as a sideband. Untagged frames pass through unmodified; per-class frame counters are exposed for CSR readout.

## Interface
- DATA_WIDTH, 512: AXI-Stream data width in bits. Byte i is at bits [8i+7:8i]; 64 bytes per beat.
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- s_axis_tdata / tkeep / tlast / tvalid  in  512/64/1/1  frames from CMAC RX, possibly tagged
- s_axis_tready  out  1  input backpressure
- m_axis_tdata / tkeep / tlast / tvalid  out  512/64/1/1  untagged frames to the RX gateway; all driven from registers
- m_axis_tready  in  1  downstream backpressure
- route_in  out  14  {src_node[1:0], src_vfpga[3:0], dst_node[1:0], dst_vfpga[3:0], 2'b00}; 0 for untagged frames
- route_tagged  out  1  1 if the current frame carried a tag
- route_valid  out  1  one-cycle pulse when route_in and route_tagged update
- cnt_tagged  out  32  count of stripped frames; wraps at 2^32
- cnt_untagged  out  32  count of passed-through frames; wraps at 2^32

## Operation
- Tag detect, first beat only:
  - Condition: keep[15:0] == 16'hFFFF and byte12 == 8'h81 and byte13 == 8'h00.
  - Frames shorter than 16 bytes are treated as untagged.
- VID decode: VID = {byte14[3:0], byte15}; route_in = {VID, 2'b00}. PCP and DEI are ignored.
- Sideband timing:
  - route_in, route_tagged and the counters update on the cycle after the first beat is accepted.
  - route_valid is high for exactly that cycle.
  - route_in and route_tagged then hold until the next frame's first beat.
- Output register:
  - It is "free" when m_axis_tvalid == 0 or m_axis_tready == 1.
  - s_axis_tready = free, except in ST_RESIDUE, where it is 0.
- States and transitions:
  - ST_HEAD, on first-beat accept:
    - Untagged: load the beat into the output register unchanged. Go to ST_PASS if !tlast, else stay.
    - Tagged, single beat (tlast): output = bytes 0–11 followed by in-bytes 16–63 in out 12–59; out keep[59:0] = {keep[63:16], keep[11:0]}; keep[63:60] = 0; tlast = 1. Stay in ST_HEAD.
    - Tagged, not last: store the compacted 60 bytes and keep in a pending register (no output). Go to ST_BODY.
  - ST_PASS: forward each accepted beat unchanged. On tlast, go to ST_HEAD.
  - ST_BODY, on accepting beat b:
    - Output = pending (bytes 0–59) followed by b bytes 0–3 (out 60–63); keep likewise.
    - pending ← b bytes 4–63.
    - If b.tlast and b.keep[4] == 1: output tlast = 0; go to ST_RESIDUE.
    - If b.tlast and b.keep[4] == 0: output tlast = 1; go to ST_HEAD.
  - ST_RESIDUE: when the output register is free, output pending with keep[63:60] = 0 and tlast = 1; go to ST_HEAD.
- tkeep is contiguous from byte 0 within every beat. Frames are not dropped or truncated.

## Timing
- Reset (aresetn low at a clock edge):
  - m_axis_tvalid, tdata, tkeep and tlast go to 0; route_* go to 0; both counters go to 0; state goes to ST_HEAD; pending is cleared.
  - s_axis_tready is forced to 0 while aresetn is low.
  - Reset mid-frame discards the partial frame; the next accepted beat is treated as a first beat.
- Latency:
  - Untagged beat, and tagged single-beat frame: output is valid 1 cycle after accept.
  - Tagged multi-beat frame: output beat n is valid 1 cycle after input beat n+1 is accepted.
  - Residue beat: 1 cycle after the tlast output beat is consumed.
- Throughput:
  - 1 beat/cycle when m_axis_tready is held high.
  - A tagged frame whose last beat has keep[4] == 1 costs one extra input-stall cycle. The input count equals the output count for that frame.
- Handshake:
  - Output is registered; tdata, tkeep and tlast stay stable while tvalid && !tready.
  - A new frame's first beat may be accepted in the same cycle the previous frame's last output is consumed.

## Test plan
- Untagged: single-beat frame with keep = 64'hFFFF_FFFF, bytes 12–13 = 08 00 → identical beat out 1 cycle later; route_tagged = 0, route_in = 0; cnt_untagged = 1.
- Tagged, 64-byte single beat:
  - Stimulus: bytes 12–15 = 81 00 0A 5B (VID = 0xA5B).
  - Required: 1 output beat with keep = 64'h0FFF_FFFF_FFFF_FFFF and out bytes 12–59 = in bytes 16–63.
  - Required sideband: route_in = 14'h296C; route_valid pulses once; cnt_tagged = 1.
- Tagged, 2 beats, second beat keep = 64'hF:
  - Beat 0 out = compacted bytes + beat1 bytes 0–3, full keep, tlast = 1.
  - Exactly 2 input beats produce 1 output beat.
- Tagged, 2 beats, second beat keep = 64'hFF:
  - 2 output beats; the second has keep = 64'hF, carries in-bytes 4–7 of beat 1, and tlast = 1.
  - s_axis_tready = 0 for the one ST_RESIDUE cycle.
- Backpressure: random m_axis_tready over 3-beat tagged frames back-to-back with untagged frames → output byte stream equals the reference-model byte stream, with no output change while stalled.
- Reset asserted in ST_BODY → all outputs are 0 on the next cycle; the following tagged frame is stripped correctly.

Source files
------------

// File: rtl/vlan_stripper.sv
// vlan_stripper: RX-path 802.1Q tag removal.
// Detects a tag at byte offset 12 of the first beat of a frame and removes the
// 4 tag bytes. The rest of the frame is shifted 4 bytes toward byte 0, so each
// output beat is built from the tail of one input beat and the head of the next.
// The decoded VID is presented as a routing sideband, and tagged/untagged frame
// counts are kept for CSR readout.
//
// Ports:
//   aclk, aresetn                clock; synchronous active-low reset
//   s_axis_t{data,keep,last,valid}, s_axis_tready   input stream (possibly tagged)
//   m_axis_t{data,keep,last,valid}, m_axis_tready   output stream (untagged), registered
//   route_in[13:0]               {VID, 2'b00} of the current frame, 0 if untagged
//   route_tagged                 current frame carried a tag
//   route_valid                  one-cycle pulse when route_in/route_tagged update
//   cnt_tagged, cnt_untagged     wrapping frame counters
module vlan_stripper #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [13:0]             route_in,
  output logic                    route_tagged,
  output logic                    route_valid,
  output logic [31:0]             cnt_tagged,
  output logic [31:0]             cnt_untagged
);

  localparam int KW  = DATA_WIDTH / 8;
  localparam int PW  = DATA_WIDTH - 32;  // pending data: one beat minus the tag
  localparam int PKW = KW - 4;

  typedef enum logic [1:0] {
    ST_HEAD,
    ST_PASS,
    ST_BODY,
    ST_RESIDUE
  } state_t;

  state_t                r_state, w_state_n;
  logic [DATA_WIDTH-1:0] r_tdata, w_tdata_n;
  logic [KW-1:0]         r_tkeep, w_tkeep_n;
  logic                  r_tlast, w_tlast_n;
  logic                  r_tvalid, w_tvalid_n;
  logic [PW-1:0]         r_pend_data, w_pend_data_n;
  logic [PKW-1:0]        r_pend_keep, w_pend_keep_n;
  logic [13:0]           r_route_in, w_route_in_n;
  logic                  r_route_tagged, w_route_tagged_n;
  logic                  r_route_valid, w_route_valid_n;
  logic [31:0]           r_cnt_tagged, w_cnt_tagged_n;
  logic [31:0]           r_cnt_untagged, w_cnt_untagged_n;

  logic                  w_free;
  logic                  w_accept;
  logic                  w_tagged;
  logic [PW-1:0]         w_comp_data;
  logic [PKW-1:0]        w_comp_keep;

  // The output register can take a new beat when it is empty or being drained.
  assign w_free        = !r_tvalid || m_axis_tready;
  assign s_axis_tready = aresetn && w_free && (r_state != ST_RESIDUE);
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  // Short first beats (fewer than 16 bytes) can never hold a full tag.
  assign w_tagged = (s_axis_tkeep[15:0] == 16'hFFFF) &&
                    (s_axis_tdata[103:96] == 8'h81) &&
                    (s_axis_tdata[111:104] == 8'h00);

  // First beat with bytes 12..15 removed: 60 bytes.
  assign w_comp_data = {s_axis_tdata[DATA_WIDTH-1:128], s_axis_tdata[95:0]};
  assign w_comp_keep = {s_axis_tkeep[KW-1:16], s_axis_tkeep[11:0]};

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;
  assign route_in      = r_route_in;
  assign route_tagged  = r_route_tagged;
  assign route_valid   = r_route_valid;
  assign cnt_tagged    = r_cnt_tagged;
  assign cnt_untagged  = r_cnt_untagged;

  // ---- next-state / next-output ----
  always_comb begin
    w_state_n        = r_state;
    w_tdata_n        = r_tdata;
    w_tkeep_n        = r_tkeep;
    w_tlast_n        = r_tlast;
    w_tvalid_n       = w_free ? 1'b0 : r_tvalid;
    w_pend_data_n    = r_pend_data;
    w_pend_keep_n    = r_pend_keep;
    w_route_in_n     = r_route_in;
    w_route_tagged_n = r_route_tagged;
    w_route_valid_n  = 1'b0;
    w_cnt_tagged_n   = r_cnt_tagged;
    w_cnt_untagged_n = r_cnt_untagged;

    case (r_state)
      ST_HEAD: begin
        if (w_accept) begin
          w_route_valid_n  = 1'b1;
          w_route_tagged_n = w_tagged;
          if (w_tagged) begin
            // PCP/DEI (byte14[7:4]) are dropped; only the VID is routed.
            w_route_in_n   = {s_axis_tdata[115:112], s_axis_tdata[127:120], 2'b00};
            w_cnt_tagged_n = r_cnt_tagged + 32'd1;
            if (s_axis_tlast) begin
              w_tdata_n  = {32'd0, w_comp_data};
              w_tkeep_n  = {4'd0, w_comp_keep};
              w_tlast_n  = 1'b1;
              w_tvalid_n = 1'b1;
            end else begin
              // Hold the compacted head until the next beat fills bytes 60..63.
              w_pend_data_n = w_comp_data;
              w_pend_keep_n = w_comp_keep;
              w_state_n     = ST_BODY;
            end
          end else begin
            w_route_in_n     = 14'd0;
            w_cnt_untagged_n = r_cnt_untagged + 32'd1;
            w_tdata_n        = s_axis_tdata;
            w_tkeep_n        = s_axis_tkeep;
            w_tlast_n        = s_axis_tlast;
            w_tvalid_n       = 1'b1;
            if (!s_axis_tlast) w_state_n = ST_PASS;
          end
        end
      end

      ST_PASS: begin
        if (w_accept) begin
          w_tdata_n  = s_axis_tdata;
          w_tkeep_n  = s_axis_tkeep;
          w_tlast_n  = s_axis_tlast;
          w_tvalid_n = 1'b1;
          if (s_axis_tlast) w_state_n = ST_HEAD;
        end
      end

      ST_BODY: begin
        if (w_accept) begin
          w_tdata_n     = {s_axis_tdata[31:0], r_pend_data};
          w_tkeep_n     = {s_axis_tkeep[3:0], r_pend_keep};
          w_tvalid_n    = 1'b1;
          w_tlast_n     = 1'b0;
          w_pend_data_n = s_axis_tdata[DATA_WIDTH-1:32];
          w_pend_keep_n = s_axis_tkeep[KW-1:4];
          if (s_axis_tlast) begin
            // Bytes beyond offset 3 of the last beat spill into one extra beat.
            if (s_axis_tkeep[4]) begin
              w_state_n = ST_RESIDUE;
            end else begin
              w_tlast_n = 1'b1;
              w_state_n = ST_HEAD;
            end
          end
        end
      end

      ST_RESIDUE: begin
        if (w_free) begin
          w_tdata_n  = {32'd0, r_pend_data};
          w_tkeep_n  = {4'd0, r_pend_keep};
          w_tlast_n  = 1'b1;
          w_tvalid_n = 1'b1;
          w_state_n  = ST_HEAD;
        end
      end

      default: w_state_n = ST_HEAD;
    endcase
  end

  // ---- registers ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state        <= ST_HEAD;
      r_tdata        <= '0;
      r_tkeep        <= '0;
      r_tlast        <= 1'b0;
      r_tvalid       <= 1'b0;
      r_pend_data    <= '0;
      r_pend_keep    <= '0;
      r_route_in     <= '0;
      r_route_tagged <= 1'b0;
      r_route_valid  <= 1'b0;
      r_cnt_tagged   <= '0;
      r_cnt_untagged <= '0;
    end else begin
      r_state        <= w_state_n;
      r_tdata        <= w_tdata_n;
      r_tkeep        <= w_tkeep_n;
      r_tlast        <= w_tlast_n;
      r_tvalid       <= w_tvalid_n;
      r_pend_data    <= w_pend_data_n;
      r_pend_keep    <= w_pend_keep_n;
      r_route_in     <= w_route_in_n;
      r_route_tagged <= w_route_tagged_n;
      r_route_valid  <= w_route_valid_n;
      r_cnt_tagged   <= w_cnt_tagged_n;
      r_cnt_untagged <= w_cnt_untagged_n;
    end
  end

endmodule

// File: tb/tb_vlan_stripper.sv
// tb_vlan_stripper: directed bench for vlan_stripper.
// Covers reset state, untagged pass-through (including a short frame with tag-like
// bytes), tagged single-beat, tagged two-beat with and without a residue beat,
// random output backpressure against a byte-stream model, and reset mid-frame.
module tb_vlan_stripper;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0]  s_axis_tkeep = '0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic [13:0]  route_in;
  logic         route_tagged;
  logic         route_valid;
  logic [31:0]  cnt_tagged;
  logic [31:0]  cnt_untagged;

  int n_total = 0;
  int n_pass  = 0;
  int exp_tag = 0;
  int exp_untag = 0;

  logic [7:0] exp_q[$];
  logic [7:0] out_q[$];
  int         exp_len[$];
  int         out_len[$];
  logic       mon_stop = 1'b0;
  int         stall_err = 0;

  always #5 aclk = ~aclk;

  vlan_stripper #(.DATA_WIDTH(512)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .route_in      (route_in),
    .route_tagged  (route_tagged),
    .route_valid   (route_valid),
    .cnt_tagged    (cnt_tagged),
    .cnt_untagged  (cnt_untagged)
  );

  function automatic logic [511:0] seq512(input logic [7:0] base);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] kmask(input logic [63:0] k);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = {8{k[i]}};
    return r;
  endfunction

  // Expected first-beat layout with the 4 tag bytes cut out; bytes 60..63 left 0.
  function automatic logic [511:0] strip_head(input logic [511:0] d);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 12; j++) r[8*j +: 8] = d[8*j +: 8];
    for (int j = 12; j < 60; j++) r[8*j +: 8] = d[8*(j+4) +: 8];
    return r;
  endfunction

  // Present one beat and return #1 after the edge on which it is accepted.
  task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int n;
    @(negedge aclk); #2;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 200) begin
      @(negedge aclk); #2;
      n++;
    end
    n_total++;
    if (n >= 200) begin
      $display("FAIL accept_timeout: s_axis_tready stayed %0b, required 1", s_axis_tready);
      s_axis_tvalid = 1'b0;
    end else begin
      n_pass++;
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %0b need 0", m_axis_tvalid); else n_pass++;
    n_total++; if (m_axis_tdata !== '0) $display("FAIL rst_tdata: got %0h need 0", m_axis_tdata); else n_pass++;
    n_total++; if (m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0) $display("FAIL rst_keep_last: got %0h/%0b need 0/0", m_axis_tkeep, m_axis_tlast); else n_pass++;
    n_total++; if (route_in !== 14'd0 || route_tagged !== 1'b0 || route_valid !== 1'b0) $display("FAIL rst_route: got %0h/%0b/%0b need 0/0/0", route_in, route_tagged, route_valid); else n_pass++;
    n_total++; if (cnt_tagged !== 32'd0 || cnt_untagged !== 32'd0) $display("FAIL rst_cnt: got %0d/%0d need 0/0", cnt_tagged, cnt_untagged); else n_pass++;
    n_total++; if (s_axis_tready !== 1'b0) $display("FAIL rst_tready: got %0b need 0", s_axis_tready); else n_pass++;
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    n_total++; if (s_axis_tready !== 1'b1) $display("FAIL post_rst_tready: got %0b need 1", s_axis_tready); else n_pass++;
  endtask

  task automatic test_untagged();
    logic [511:0] d;
    d = seq512(8'h10);
    d[103:96] = 8'h08; d[111:104] = 8'h00;
    drive_beat(d, 64'hFFFF_FFFF, 1'b1);
    exp_untag++;
    n_total++; if (m_axis_tvalid !== 1'b1) $display("FAIL untag_tvalid: got %0b need 1", m_axis_tvalid); else n_pass++;
    n_total++; if (m_axis_tdata !== d) $display("FAIL untag_tdata: got %0h need %0h", m_axis_tdata, d); else n_pass++;
    n_total++; if (m_axis_tkeep !== 64'hFFFF_FFFF || m_axis_tlast !== 1'b1) $display("FAIL untag_keep_last: got %0h/%0b need ffffffff/1", m_axis_tkeep, m_axis_tlast); else n_pass++;
    n_total++; if (route_valid !== 1'b1 || route_tagged !== 1'b0 || route_in !== 14'd0) $display("FAIL untag_route: got v%0b t%0b r%0h need v1 t0 r0", route_valid, route_tagged, route_in); else n_pass++;
    n_total++; if (cnt_untagged !== 32'(exp_untag) || cnt_tagged !== 32'(exp_tag)) $display("FAIL untag_cnt: got %0d/%0d need %0d/%0d", cnt_untagged, cnt_tagged, exp_untag, exp_tag); else n_pass++;
    @(posedge aclk); #1;
    n_total++; if (m_axis_tvalid !== 1'b0 || route_valid !== 1'b0) $display("FAIL untag_after: got tvalid %0b route_valid %0b need 0/0", m_axis_tvalid, route_valid); else n_pass++;
    // 15-byte frame with tag bytes at 12..13 is too short to carry a tag.
    d = seq512(8'h20);
    d[103:96] = 8'h81; d[111:104] = 8'h00;
    drive_beat(d, 64'h7FFF, 1'b1);
    exp_untag++;
    n_total++; if (m_axis_tdata !== d || m_axis_tkeep !== 64'h7FFF) $display("FAIL short_pass: got %0h keep %0h need %0h keep 7fff", m_axis_tdata, m_axis_tkeep, d); else n_pass++;
    n_total++; if (route_tagged !== 1'b0 || cnt_untagged !== 32'(exp_untag)) $display("FAIL short_untagged: got t%0b cnt %0d need t0 cnt %0d", route_tagged, cnt_untagged, exp_untag); else n_pass++;
  endtask

  task automatic test_tagged_single();
    logic [511:0] d, e;
    logic [63:0]  ek;
    d = seq512(8'h40);
    d[103:96] = 8'h81; d[111:104] = 8'h00; d[119:112] = 8'h0A; d[127:120] = 8'h5B;
    e  = strip_head(d);
    ek = 64'h0FFF_FFFF_FFFF_FFFF;
    drive_beat(d, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    exp_tag++;
    n_total++; if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) $display("FAIL tag1_vl: got %0b/%0b need 1/1", m_axis_tvalid, m_axis_tlast); else n_pass++;
    n_total++; if (m_axis_tkeep !== ek) $display("FAIL tag1_keep: got %0h need %0h", m_axis_tkeep, ek); else n_pass++;
    n_total++; if ((m_axis_tdata & kmask(ek)) !== e) $display("FAIL tag1_data: got %0h need %0h", m_axis_tdata & kmask(ek), e); else n_pass++;
    n_total++; if (route_in !== 14'h296C || route_tagged !== 1'b1 || route_valid !== 1'b1) $display("FAIL tag1_route: got r%0h t%0b v%0b need r296c t1 v1", route_in, route_tagged, route_valid); else n_pass++;
    n_total++; if (cnt_tagged !== 32'(exp_tag)) $display("FAIL tag1_cnt: got %0d need %0d", cnt_tagged, exp_tag); else n_pass++;
    @(posedge aclk); #1;
    n_total++; if (route_valid !== 1'b0 || route_in !== 14'h296C || m_axis_tvalid !== 1'b0) $display("FAIL tag1_hold: got v%0b r%0h tv%0b need v0 r296c tv0", route_valid, route_in, m_axis_tvalid); else n_pass++;
  endtask

  task automatic test_tagged_two_short();
    logic [511:0] b0, b1, e;
    b0 = seq512(8'h80);
    b0[103:96] = 8'h81; b0[111:104] = 8'h00; b0[119:112] = 8'hE1; b0[127:120] = 8'h23;
    b1 = seq512(8'hC0);
    e = strip_head(b0);
    e[511:480] = b1[31:0];
    drive_beat(b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    exp_tag++;
    n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL two_no_out: got %0b need 0", m_axis_tvalid); else n_pass++;
    n_total++; if (route_in !== 14'h048C || route_valid !== 1'b1 || route_tagged !== 1'b1) $display("FAIL two_route: got r%0h v%0b t%0b need r48c v1 t1", route_in, route_valid, route_tagged); else n_pass++;
    drive_beat(b1, 64'hF, 1'b1);
    n_total++; if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tkeep !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL two_beat: got v%0b l%0b k%0h need v1 l1 full", m_axis_tvalid, m_axis_tlast, m_axis_tkeep); else n_pass++;
    n_total++; if (m_axis_tdata !== e) $display("FAIL two_data: got %0h need %0h", m_axis_tdata, e); else n_pass++;
    n_total++; if (cnt_tagged !== 32'(exp_tag)) $display("FAIL two_cnt: got %0d need %0d", cnt_tagged, exp_tag); else n_pass++;
    @(posedge aclk); #1;
    n_total++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) $display("FAIL two_only_one: got tv%0b rdy%0b need 0/1", m_axis_tvalid, s_axis_tready); else n_pass++;
  endtask

  task automatic test_tagged_residue();
    logic [511:0] b0, b1, e;
    b0 = seq512(8'h05);
    b0[103:96] = 8'h81; b0[111:104] = 8'h00; b0[119:112] = 8'h0F; b0[127:120] = 8'hFF;
    b1 = seq512(8'h77);
    e = strip_head(b0);
    e[511:480] = b1[31:0];
    drive_beat(b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    exp_tag++;
    n_total++; if (route_in !== 14'h3FFC) $display("FAIL res_route: got %0h need 3ffc", route_in); else n_pass++;
    drive_beat(b1, 64'hFF, 1'b1);
    n_total++; if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0 || m_axis_tkeep !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL res_first: got v%0b l%0b k%0h need v1 l0 full", m_axis_tvalid, m_axis_tlast, m_axis_tkeep); else n_pass++;
    n_total++; if (m_axis_tdata !== e) $display("FAIL res_first_data: got %0h need %0h", m_axis_tdata, e); else n_pass++;
    n_total++; if (s_axis_tready !== 1'b0) $display("FAIL res_stall: got %0b need 0", s_axis_tready); else n_pass++;
    @(posedge aclk); #1;
    n_total++; if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tkeep !== 64'hF) $display("FAIL res_beat: got v%0b l%0b k%0h need v1 l1 k f", m_axis_tvalid, m_axis_tlast, m_axis_tkeep); else n_pass++;
    n_total++; if (m_axis_tdata[31:0] !== b1[63:32]) $display("FAIL res_data: got %0h need %0h", m_axis_tdata[31:0], b1[63:32]); else n_pass++;
    n_total++; if (s_axis_tready !== 1'b1) $display("FAIL res_ready_back: got %0b need 1", s_axis_tready); else n_pass++;
    @(posedge aclk); #1;
    n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL res_done: got %0b need 0", m_axis_tvalid); else n_pass++;
  endtask

  task automatic bp_driver();
    logic [63:0]  lastk [5];
    logic [511:0] d;
    logic [63:0]  k;
    logic         tg;
    int           nb, flen, n;
    lastk = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hF, 64'hFF, 64'h1F, 64'h0000_FFFF_FFFF_FFFF};
    for (int f = 0; f < 10; f++) begin
      tg   = (f % 2 == 0);
      nb   = tg ? 3 : ((f % 4 == 1) ? 1 : 2);
      flen = 0;
      for (int b = 0; b < nb; b++) begin
        d = rnd512();
        if (b != nb - 1)   k = 64'hFFFF_FFFF_FFFF_FFFF;
        else if (tg)       k = lastk[f/2];
        else if (nb == 1)  k = 64'h3FF;
        else               k = 64'hFF_FFFF;
        if (b == 0) begin
          if (tg) begin
            d[103:96] = 8'h81; d[111:104] = 8'h00;
          end else begin
            d[103:96] = 8'h08;
          end
        end
        for (int i = 0; i < 64; i++)
          if (k[i] && !(tg && b == 0 && i >= 12 && i < 16)) begin
            exp_q.push_back(d[8*i +: 8]);
            flen++;
          end
        drive_beat(d, k, b == nb - 1);
      end
      exp_len.push_back(flen);
      if (tg) exp_tag++; else exp_untag++;
    end
    n = 0;
    while (out_len.size() < exp_len.size() && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    n_total++; if (out_len.size() != exp_len.size()) $display("FAIL bp_frames: got %0d need %0d", out_len.size(), exp_len.size()); else n_pass++;
    mon_stop = 1'b1;
  endtask

  task automatic bp_monitor();
    logic [511:0] pd;
    logic [63:0]  pk;
    logic         pl, pstall;
    int           cur;
    pstall = 1'b0; cur = 0; pd = '0; pk = '0; pl = 1'b0;
    while (!mon_stop) begin
      @(negedge aclk);
      m_axis_tready = ($urandom_range(0, 99) < 60);
      #1;
      if (pstall && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tkeep !== pk || m_axis_tlast !== pl))
        stall_err++;
      if (m_axis_tvalid && m_axis_tready) begin
        for (int i = 0; i < 64; i++)
          if (m_axis_tkeep[i]) begin
            out_q.push_back(m_axis_tdata[8*i +: 8]);
            cur++;
          end
        if (m_axis_tlast) begin
          out_len.push_back(cur);
          cur = 0;
        end
        pstall = 1'b0;
      end else if (m_axis_tvalid) begin
        pstall = 1'b1;
        pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
      end else begin
        pstall = 1'b0;
      end
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic test_backpressure();
    int bad, lbad;
    exp_q.delete(); out_q.delete(); exp_len.delete(); out_len.delete();
    mon_stop = 1'b0;
    fork
      bp_driver();
      bp_monitor();
    join
    bad = 0;
    lbad = 0;
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      if (out_q[i] !== exp_q[i]) bad++;
    for (int i = 0; i < exp_len.size() && i < out_len.size(); i++)
      if (out_len[i] != exp_len[i]) lbad++;
    n_total++; if (out_q.size() != exp_q.size()) $display("FAIL bp_bytes: got %0d need %0d", out_q.size(), exp_q.size()); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL bp_stream: got %0d byte errors need 0", bad); else n_pass++;
    n_total++; if (lbad != 0) $display("FAIL bp_lengths: got %0d frame length errors need 0", lbad); else n_pass++;
    n_total++; if (stall_err != 0) $display("FAIL bp_stable: got %0d changes while stalled need 0", stall_err); else n_pass++;
    n_total++; if (cnt_tagged !== 32'(exp_tag) || cnt_untagged !== 32'(exp_untag)) $display("FAIL bp_cnt: got %0d/%0d need %0d/%0d", cnt_tagged, cnt_untagged, exp_tag, exp_untag); else n_pass++;
  endtask

  task automatic test_reset_body();
    logic [511:0] b0, d, e;
    b0 = seq512(8'h33);
    b0[103:96] = 8'h81; b0[111:104] = 8'h00; b0[119:112] = 8'h00; b0[127:120] = 8'h44;
    drive_beat(b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(negedge aclk); aresetn = 1'b0;
    @(posedge aclk); #1;
    n_total++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0) $display("FAIL rb_out: got v%0b k%0h l%0b need all 0", m_axis_tvalid, m_axis_tkeep, m_axis_tlast); else n_pass++;
    n_total++; if (route_in !== 14'd0 || route_tagged !== 1'b0 || route_valid !== 1'b0) $display("FAIL rb_route: got r%0h t%0b v%0b need 0", route_in, route_tagged, route_valid); else n_pass++;
    n_total++; if (cnt_tagged !== 32'd0 || cnt_untagged !== 32'd0 || s_axis_tready !== 1'b0) $display("FAIL rb_cnt_rdy: got %0d/%0d rdy %0b need 0/0/0", cnt_tagged, cnt_untagged, s_axis_tready); else n_pass++;
    @(negedge aclk); aresetn = 1'b1;
    d = seq512(8'h90);
    d[103:96] = 8'h81; d[111:104] = 8'h00; d[119:112] = 8'h00; d[127:120] = 8'h01;
    e = strip_head(d);
    drive_beat(d, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    n_total++; if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tkeep !== 64'h0FFF_FFFF_FFFF_FFFF) $display("FAIL rb_next_beat: got v%0b l%0b k%0h need v1 l1 k0fff..", m_axis_tvalid, m_axis_tlast, m_axis_tkeep); else n_pass++;
    n_total++; if ((m_axis_tdata & kmask(64'h0FFF_FFFF_FFFF_FFFF)) !== e) $display("FAIL rb_next_data: got %0h need %0h", m_axis_tdata, e); else n_pass++;
    n_total++; if (route_in !== 14'h0004 || cnt_tagged !== 32'd1 || cnt_untagged !== 32'd0) $display("FAIL rb_next_side: got r%0h %0d/%0d need r4 1/0", route_in, cnt_tagged, cnt_untagged); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_untagged();
    test_tagged_single();
    test_tagged_two_short();
    test_tagged_residue();
    test_backpressure();
    test_reset_body();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
